// File: rtl/input_load_ctrl.sv
// rtl/input_load_ctrl.sv - word-input load sequencer: request, capture and write words to memory
// Stops after the latched count, on per-word timeout, or on abort.
module input_load_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              in_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   loaded
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]     TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]     TIMER_ONE  = TW'(1);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [ADDR_W:0]   loaded_q, loaded_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        loaded_d    = loaded_q;
        timer_d     = timer_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    ptr_d       = base_addr;
                    remaining_d = word_count;
                    loaded_d    = '0;
                    err_d       = 1'b0;
                    state_d     = (word_count != '0) ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                timer_d = '0;
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // abort outranks both a same-cycle valid and the timeout
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (in_valid) begin
                    wdata_d = in_data;
                    state_d = S_WRITE;
                end else if (timer_q == TIMER_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            S_WRITE: begin
                ptr_d       = ptr_q + PTR_ONE;
                remaining_d = remaining_q - CNT_ONE;
                loaded_d    = loaded_q + CNT_ONE;
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = (remaining_q == CNT_ONE) ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            loaded_q    <= '0;
            timer_q     <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            loaded_q    <= loaded_d;
            timer_q     <= timer_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
        end
    end

    assign in_start  = (state_q == S_REQ);
    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = mem_we ? ptr_q : '0;
    assign mem_wdata = mem_we ? wdata_q : '0;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign loaded    = loaded_q;

endmodule

// File: tb/tb_input_load_ctrl.sv
// tb/tb_input_load_ctrl.sv - scoreboard bench for input_load_ctrl
module tb_input_load_ctrl;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;

    logic              clk;
    logic              rst_n;
    logic              go;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              in_start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   loaded;

    input_load_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (go),
        .abort     (abort),
        .base_addr (base_addr),
        .word_count(word_count),
        .in_start  (in_start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .loaded    (loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int n_start     = 0;
    int n_wait      = 0;
    bit src_en      = 1'b0;

    logic [DATA_W-1:0]        src_q[$];
    logic [ADDR_W+DATA_W-1:0] exp_wr[$];
    logic [ADDR_W+1:0]        exp_done[$];
    logic [ADDR_W+DATA_W-1:0] e_wr;
    logic [ADDR_W+1:0]        e_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops expected writes and done events whenever the DUT presents them
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_start) n_start++;
            if (busy && !in_start && !mem_we && !done) n_wait++;
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: addr %0h data %0h, no write expected", mem_addr, mem_wdata);
                end else begin
                    e_wr = exp_wr.pop_front();
                    check("write_addr", 64'(mem_addr), 64'(e_wr[ADDR_W+DATA_W-1:DATA_W]));
                    check("write_data", 64'(mem_wdata), 64'(e_wr[DATA_W-1:0]));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: err %0d loaded %0d, no done expected", err, loaded);
                end else begin
                    e_done = exp_done.pop_front();
                    check("done_err", 64'(err), 64'(e_done[ADDR_W+1]));
                    check("done_loaded", 64'(loaded), 64'(e_done[ADDR_W:0]));
                end
            end
        end
    end

    // input source: answers each in_start with a valid word one cycle later
    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && in_start && src_en) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = (src_q.size() != 0) ? src_q.pop_front() : '0;
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = '0;
            end
        end
    end

    task automatic start_load(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] cnt);
        @(negedge clk);
        go         = 1'b1;
        base_addr  = base;
        word_count = cnt;
        @(negedge clk);
        go         = 1'b0;
        base_addr  = '0;
        word_count = '0;
    endtask

    task automatic wait_idle(input string name);
        int i = 0;
        while (busy && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, i);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, w0, k;
        rst_n      = 1'b1;
        go         = 1'b0;
        abort      = 1'b0;
        base_addr  = '0;
        word_count = '0;

        // reset asserted mid-cycle
        #3 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_err", 64'(err), 0);
        check("rst_loaded", 64'(loaded), 0);
        check("rst_in_start", 64'(in_start), 0);
        check("rst_mem_we", 64'(mem_we), 0);
        check("rst_mem_addr", 64'(mem_addr), 0);
        check("rst_mem_wdata", 64'(mem_wdata), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // three words from 8'h10
        src_en = 1'b1;
        src_q.push_back(32'h0000000A);
        src_q.push_back(32'h0000000B);
        src_q.push_back(32'h0000000C);
        exp_wr.push_back({8'h10, 32'h0000000A});
        exp_wr.push_back({8'h11, 32'h0000000B});
        exp_wr.push_back({8'h12, 32'h0000000C});
        exp_done.push_back({1'b0, 9'd3});
        s0 = n_start;
        start_load(8'h10, 9'd3);
        check("t2_first_in_start", 64'(in_start), 1);
        wait_idle("t2");
        check("t2_in_starts", 64'(n_start - s0), 3);
        check("t2_loaded", 64'(loaded), 3);
        check("t2_err", 64'(err), 0);

        // zero count: done next cycle, no request, no write
        exp_done.push_back({1'b0, 9'd0});
        s0 = n_start;
        start_load(8'h30, 9'd0);
        check("t3_done", 64'(done), 1);
        check("t3_busy_in_done", 64'(busy), 1);
        wait_idle("t3");
        check("t3_in_starts", 64'(n_start - s0), 0);
        check("t3_loaded", 64'(loaded), 0);

        // silent source: one request, 16 WAIT cycles, timeout
        src_en = 1'b0;
        exp_done.push_back({1'b1, 9'd0});
        s0 = n_start;
        w0 = n_wait;
        start_load(8'h50, 9'd2);
        wait_idle("t4");
        check("t4_in_starts", 64'(n_start - s0), 1);
        check("t4_wait_cycles", 64'(n_wait - w0), 16);
        check("t4_err", 64'(err), 1);
        check("t4_loaded", 64'(loaded), 0);

        // address wrap, go during load ignored
        src_en = 1'b1;
        src_q.push_back(32'h11111111);
        src_q.push_back(32'h22222222);
        exp_wr.push_back({8'hFF, 32'h11111111});
        exp_wr.push_back({8'h00, 32'h22222222});
        exp_done.push_back({1'b0, 9'd2});
        start_load(8'hFF, 9'd2);
        @(negedge clk);
        go         = 1'b1;
        base_addr  = 8'h55;
        word_count = 9'd7;
        @(negedge clk);
        go         = 1'b0;
        base_addr  = '0;
        word_count = '0;
        wait_idle("t5");
        check("t5_loaded", 64'(loaded), 2);
        check("t5_err", 64'(err), 0);

        // abort in WAIT of word 3, same cycle as the source's valid
        src_q.push_back(32'hA0000001);
        src_q.push_back(32'hA0000002);
        src_q.push_back(32'hA0000003);
        exp_wr.push_back({8'h20, 32'hA0000001});
        exp_wr.push_back({8'h21, 32'hA0000002});
        exp_done.push_back({1'b1, 9'd2});
        start_load(8'h20, 9'd4);
        k = (in_start) ? 1 : 0;
        for (int i = 0; i < 50 && k < 3; i++) begin
            @(negedge clk);
            if (in_start) k++;
        end
        check("t6_third_request_seen", 64'(k), 3);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle("t6");
        check("t6_err", 64'(err), 1);
        check("t6_loaded", 64'(loaded), 2);
        src_q.delete();

        // new go clears err; reset mid-load gives no done pulse
        src_q.push_back(32'hB0000001);
        src_q.push_back(32'hB0000002);
        src_q.push_back(32'hB0000003);
        exp_wr.push_back({8'h40, 32'hB0000001});
        start_load(8'h40, 9'd3);
        check("t6b_err_cleared", 64'(err), 0);
        k = 0;
        for (int i = 0; i < 20 && k == 0; i++) begin
            @(negedge clk);
            if (mem_we) k = 1;
        end
        check("t6b_first_write_seen", 64'(k), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6b_rst_busy", 64'(busy), 0);
        check("t6b_rst_in_start", 64'(in_start), 0);
        check("t6b_rst_loaded", 64'(loaded), 0);
        check("t6b_rst_done", 64'(done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        src_q.delete();
        repeat (4) @(negedge clk);
        check("busy_after_reset", 64'(busy), 0);

        check("leftover_writes", 64'(exp_wr.size()), 0);
        check("leftover_dones", 64'(exp_done.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
